fetch_warp_sched: RTL

Per-core warp fetch scheduler driving the instruction-fetch request path into the icache stage. Keeps per-warp PC, thread mask, active and in-flight state, and picks one eligible warp per cycle round-robin. Emits a registered valid/ready fetch request (wid, PC, tmask, uuid). Allows at most one outstanding fetch per warp until decode or branch resolution releases it.

---
 rtl/fetch_sched_pkg.sv | 25 ++
 rtl/rr_warp_arbiter.sv | 42 ++++
 rtl/fetch_warp_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fetch_sched_pkg.sv
// Shared geometry and types for the warp fetch scheduler.
// Warp count, thread count, PC and uuid widths are set here for the whole core.
package fetch_sched_pkg;

    localparam int NUM_WARPS   = 4;
    localparam int NUM_THREADS = 4;
    localparam int XLEN        = 32;
    localparam int UUID_W      = 20;
    localparam int NW_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    typedef logic [NW_W-1:0]        wid_t;
    typedef logic [NUM_THREADS-1:0] tmask_t;
    typedef logic [XLEN-1:0]        pc_t;
    typedef logic [UUID_W-1:0]      uuid_t;

    localparam pc_t PC_STEP = pc_t'(4);

    typedef struct packed {
        logic   active;
        logic   inflight;
        pc_t    PC;
        tmask_t tmask;
    } warp_state_t;

endpackage

// File: rtl/rr_warp_arbiter.sv
// Round-robin warp picker: combinational grant, pointer holds the last accepted grant.
// Search starts one past the last grant, so a lone requester can win repeatedly.
module rr_warp_arbiter
    import fetch_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WARPS-1:0] req,
    input  logic                 accept,
    output logic                 gnt_valid,
    output wid_t                 gnt_wid
);

    wid_t ptr_q;
    wid_t ptr_d;

    always_comb begin
        int idx;
        gnt_valid = 1'b0;
        gnt_wid   = '0;
        idx       = 0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_wid   = wid_t'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) ptr_d = gnt_wid;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fetch_warp_sched.sv
// Per-core warp fetch scheduler: one registered icache fetch request per cycle, one outstanding per warp.
// Optional perf counters enabled by defining FETCH_SCHED_PERF_EN.
module fetch_warp_sched
    import fetch_sched_pkg::*;
#(
    parameter logic [XLEN-1:0] STARTUP_ADDR = 32'h8000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spawn_valid,
    input  logic [NW_W-1:0]        spawn_wid,
    input  logic [XLEN-1:0]        spawn_pc,
    input  logic [NUM_THREADS-1:0] spawn_tmask,
    output logic                   ifetch_req_valid,
    input  logic                   ifetch_req_ready,
    output logic [NW_W-1:0]        ifetch_req_wid,
    output logic [XLEN-1:0]        ifetch_req_PC,
    output logic [NUM_THREADS-1:0] ifetch_req_tmask,
    output logic [UUID_W-1:0]      ifetch_req_uuid,
    input  logic                   unlock_valid,
    input  logic [NW_W-1:0]        unlock_wid,
    input  logic                   branch_valid,
    input  logic [NW_W-1:0]        branch_wid,
    input  logic                   branch_taken,
    input  logic [XLEN-1:0]        branch_dest,
    input  logic                   tmc_valid,
    input  logic [NW_W-1:0]        tmc_wid,
    input  logic [NUM_THREADS-1:0] tmc_tmask,
    output logic                   busy
`ifdef FETCH_SCHED_PERF_EN
   ,output logic [31:0]            perf_stall_cycles,
    output logic [31:0]            perf_idle_cycles
`endif
);

    warp_state_t ws_q [NUM_WARPS];
    warp_state_t ws_d [NUM_WARPS];

    logic   valid_q;
    wid_t   wid_q;
    pc_t    pc_q;
    tmask_t tmask_q;
    uuid_t  uuid_q;
    uuid_t  uuid_cnt_q;

    logic [NUM_WARPS-1:0] active_vec;
    logic [NUM_WARPS-1:0] elig_vec;
    logic                 gnt_valid;
    wid_t                 gnt_wid;
    logic                 fire;
    logic                 load;

    always_comb begin
        active_vec = '0;
        elig_vec   = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            active_vec[w] = ws_q[w].active;
            elig_vec[w]   = ws_q[w].active & ~ws_q[w].inflight;
        end
    end

    assign fire = valid_q & ifetch_req_ready;
    // A stalled request blocks new picks so the output stays stable.
    assign load = (~valid_q | ifetch_req_ready) & gnt_valid;

    rr_warp_arbiter u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (elig_vec),
        .accept    (load),
        .gnt_valid (gnt_valid),
        .gnt_wid   (gnt_wid)
    );

    // Later assignments win: load < unlock < branch < tmc < spawn.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) ws_d[w] = ws_q[w];
        if (load) begin
            ws_d[gnt_wid].inflight = 1'b1;
            ws_d[gnt_wid].PC       = ws_q[gnt_wid].PC + PC_STEP;
        end
        if (unlock_valid && ws_q[unlock_wid].inflight)
            ws_d[unlock_wid].inflight = 1'b0;
        if (branch_valid && ws_q[branch_wid].inflight) begin
            ws_d[branch_wid].inflight = 1'b0;
            if (branch_taken) ws_d[branch_wid].PC = branch_dest;
        end
        if (tmc_valid) begin
            ws_d[tmc_wid].tmask = tmc_tmask;
            if (tmc_tmask == '0) ws_d[tmc_wid].active = 1'b0;
        end
        if (spawn_valid) begin
            ws_d[spawn_wid].active   = 1'b1;
            ws_d[spawn_wid].inflight = 1'b0;
            ws_d[spawn_wid].PC       = spawn_pc;
            ws_d[spawn_wid].tmask    = spawn_tmask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) ws_q[w] <= '0;
            ws_q[0]    <= '{active: 1'b1, inflight: 1'b0, PC: STARTUP_ADDR, tmask: tmask_t'(1)};
            valid_q    <= 1'b0;
            wid_q      <= '0;
            pc_q       <= '0;
            tmask_q    <= '0;
            uuid_q     <= '0;
            uuid_cnt_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) ws_q[w] <= ws_d[w];
            if (load) begin
                valid_q    <= 1'b1;
                wid_q      <= gnt_wid;
                pc_q       <= ws_q[gnt_wid].PC;
                tmask_q    <= ws_q[gnt_wid].tmask;
                uuid_q     <= uuid_cnt_q;
                uuid_cnt_q <= uuid_cnt_q + uuid_t'(1);
            end else if (fire) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Releasing a warp with no outstanding fetch points at a decode/branch bookkeeping bug upstream.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!unlock_valid || ws_q[unlock_wid].inflight);
            assert (!branch_valid || ws_q[branch_wid].inflight);
        end
    end

    assign ifetch_req_valid = valid_q;
    assign ifetch_req_wid   = wid_q;
    assign ifetch_req_PC    = pc_q;
    assign ifetch_req_tmask = tmask_q;
    assign ifetch_req_uuid  = uuid_q;
    assign busy             = |active_vec;

`ifdef FETCH_SCHED_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] idle_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            idle_q  <= '0;
        end else begin
            if (valid_q && !ifetch_req_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (busy && !valid_q && !gnt_valid && idle_q != '1) idle_q <= idle_q + 32'd1;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_idle_cycles  = idle_q;
`endif

endmodule
